johnson_tdm_scheduler: RTL and testbench
========================================

JOHNSON_TDM_SCHEDULER -- requirements
Module: johnson_tdm_scheduler

Interface
REQ-001 The block SHALL have parameter JC_WIDTH, default 8: Johnson register width, giving 2*JC_WIDTH slots per frame.
REQ-002 The block SHALL have parameter NREQ, default 4: number of requesters; NREQ SHALL divide 2*JC_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port clear_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin or resume scheduling.
REQ-006 The block SHALL have port stop, input, 1 bit: pause scheduling.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous return to IDLE with counter zeroed.
REQ-008 The block SHALL have port req, input, NREQ bits: per-requester access request, level-sensitive.
REQ-009 The block SHALL have port gnt, output, NREQ bits: registered grant, one-hot or zero.
REQ-010 The block SHALL have port slot, output, 4 bits: current decoded slot index, 0..15.
REQ-011 The block SHALL have port frame_pulse, output, 1 bit: high for one cycle when a frame completes.
REQ-012 The block SHALL have port frame_cnt, output, 8 bits: completed-frame count.
REQ-013 The block SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-014 The block SHALL have port err, output, 1 bit: sticky flag for an illegal Johnson pattern.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-016 FSM transitions SHALL be: IDLE to RUN on start; RUN to PAUSE on stop; PAUSE to RUN on start; any state to IDLE on flush.
REQ-017 Input priority SHALL be flush, then stop, then start; stop together with start in RUN SHALL give PAUSE, and in PAUSE SHALL stay PAUSE.
REQ-018 In RUN the Johnson register jc SHALL shift left each cycle with ~jc[MSB] entering bit 0 (00000000 to 00000001 to ... to 11111111 to 11111110 to ... to 10000000 to 00000000).
REQ-019 In PAUSE jc SHALL hold its value; in IDLE and on flush jc SHALL be 0.
REQ-020 Slot decode SHALL be: slot = popcount(jc) if jc[MSB]=0, else slot = 2*JC_WIDTH - popcount(jc).
REQ-021 The slot owner SHALL be slot mod NREQ.
REQ-022 In RUN, gnt SHALL equal onehot(owner) one cycle after the slot is presented if req[owner]=1, else 0 (unless borrowing, REQ-031).
REQ-023 gnt SHALL be 0 in IDLE and in PAUSE, and SHALL be 0 in the cycle after leaving RUN.
REQ-024 On the jc transition 10000000 to 00000000, frame_pulse SHALL assert for one cycle and frame_cnt SHALL increment, wrapping from 255 to 0.
REQ-025 If jc holds a non-Johnson pattern, the next edge SHALL load jc to 0, set err and suppress gnt for that cycle.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 clear_n low SHALL asynchronously force state to IDLE and jc, gnt, frame_pulse, frame_cnt and err to 0.
REQ-028 Reset assertion mid-frame SHALL discard the frame with no frame_pulse.
REQ-029 After reset deassertion, the first RUN cycle SHALL start at slot 0.

Configuration
REQ-030 The work-conserving borrow feature SHALL be compiled in only when macro JOHNSON_TDM_SCHEDULER_BORROW_EN is defined.
REQ-031 With the macro defined, an idle owner's slot SHALL be granted to the first requesting index searching upward, with wrap, from owner+1.
REQ-032 Without the macro, an idle owner's slot SHALL yield gnt=0 (strict TDM).

Structure
REQ-033 Package johnson_tdm_pkg SHALL hold the state enum (IDLE/RUN/PAUSE), JC_WIDTH and NREQ defaults, and the NSLOT constant.
REQ-034 Sub-module jc_slot_decode SHALL contain the combinational jc-to-slot decode and the legality check.

Verification
REQ-035 Reset, start, req=4'b1111 held for 16 cycles SHALL give gnt sequence 0001,0010,0100,1000 repeated 4 times, one frame_pulse and frame_cnt=1.
REQ-036 Reset, start, req=4'b0100, strict build SHALL give gnt=0100 only in slots 2,6,10,14 and 0 otherwise.
REQ-037 With req=4'b0100 and BORROW_EN defined, gnt SHALL be 0100 in every RUN cycle.
REQ-038 Stop at slot 5, hold 3 cycles, then start SHALL keep gnt=0 while paused and resume at slot 5; start and stop asserted together in RUN SHALL give PAUSE.
REQ-039 Running 256 frames SHALL give frame_cnt wrapping to 0; flush at slot 9 SHALL give IDLE, slot=0 and busy=0 next cycle.
REQ-040 Forcing jc=8'b01010000 SHALL give jc=0 and err=1 next edge; err SHALL stay 1 until clear_n is pulsed low.

Source files
------------

// File: rtl/johnson_tdm_scheduler_pkg.sv
// Shared types and defaults for the Johnson-counter TDM scheduler.
package johnson_tdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sched_state_t;

  localparam int JC_WIDTH_DEF = 8;
  localparam int NREQ_DEF     = 4;
  localparam int NSLOT        = 2 * JC_WIDTH_DEF;
  localparam int SLOT_W       = 4;

endpackage

// File: rtl/johnson_tdm_scheduler_jc_slot_decode.sv
// Combinational Johnson-register decode: slot index from popcount folded on
// the MSB, plus a legality check (a Johnson pattern has at most one 0/1 edge).
module jc_slot_decode
  import johnson_tdm_pkg::*;
#(
  parameter int JC_WIDTH = JC_WIDTH_DEF
) (
  input  logic [JC_WIDTH-1:0] jc,
  output logic [SLOT_W-1:0]   slot,
  output logic                legal
);

  localparam int CW = $clog2(2 * JC_WIDTH + 1);

  logic [CW-1:0]       ones;
  logic [CW-1:0]       idx;
  logic [JC_WIDTH-2:0] edges;

  // popcount, fold on MSB into 0..2N-1, and count adjacent-bit transitions
  always_comb begin
    ones = '0;
    for (int i = 0; i < JC_WIDTH; i++) begin
      ones = ones + CW'(jc[i]);
    end
    if (jc[JC_WIDTH-1]) begin
      idx = CW'(2 * JC_WIDTH) - ones;
    end else begin
      idx = ones;
    end
    slot  = SLOT_W'(idx);
    edges = jc[JC_WIDTH-1:1] ^ jc[JC_WIDTH-2:0];
    legal = ((edges & (edges - (JC_WIDTH-1)'(1))) == '0);
  end

endmodule

// File: rtl/johnson_tdm_scheduler.sv
// Johnson-counter time-division scheduler: each of 2*JC_WIDTH slots belongs to
// requester (slot mod NREQ); grants are registered one cycle after the slot.
// Optional work-conserving borrowing of idle slots: JOHNSON_TDM_SCHEDULER_BORROW_EN.
module johnson_tdm_scheduler
  import johnson_tdm_pkg::*;
#(
  parameter int JC_WIDTH = JC_WIDTH_DEF,
  parameter int NREQ     = NREQ_DEF
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            start,
  input  logic            stop,
  input  logic            flush,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [3:0]      slot,
  output logic            frame_pulse,
  output logic [7:0]      frame_cnt,
  output logic            busy,
  output logic            err
);

  localparam logic [JC_WIDTH-1:0] JC_LAST = {1'b1, {(JC_WIDTH-1){1'b0}}};

  sched_state_t    state;
  sched_state_t    state_nxt;
  logic [JC_WIDTH-1:0] jc;
  logic            jc_legal;
  logic            advance;
  logic [NREQ-1:0] grant;
  int              owner;

  jc_slot_decode #(.JC_WIDTH(JC_WIDTH)) u_decode (
    .jc    (jc),
    .slot  (slot),
    .legal (jc_legal)
  );

  assign busy    = (state != IDLE);
  assign advance = (state == RUN) && (state_nxt == RUN);

  // next-state logic: flush beats stop beats start
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (stop) state_nxt = PAUSE;
        PAUSE:   if (start && !stop) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // slot owner grant, optionally lending an idle slot to the nearest requester above
  always_comb begin
    grant = '0;
    owner = int'(slot) % NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (i == owner && req[i]) grant[i] = 1'b1;
    end
`ifdef JOHNSON_TDM_SCHEDULER_BORROW_EN
    if (grant == '0) begin
      for (int k = NREQ - 1; k >= 1; k--) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == ((owner + k) % NREQ) && req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
          end
        end
      end
    end
`endif
  end

  // state, Johnson register, registered grant, frame counting and error flag
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      jc          <= '0;
      gnt         <= '0;
      frame_pulse <= 1'b0;
      frame_cnt   <= 8'd0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= '0;
      frame_pulse <= 1'b0;
      if (!jc_legal) begin
        jc  <= '0;
        err <= 1'b1;
      end else if (state_nxt == IDLE) begin
        jc <= '0;
      end else if (advance) begin
        jc  <= {jc[JC_WIDTH-2:0], ~jc[JC_WIDTH-1]};
        gnt <= grant;
        if (jc == JC_LAST) begin
          frame_pulse <= 1'b1;
          frame_cnt   <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_tdm_scheduler.sv
// Scoreboard bench for johnson_tdm_scheduler: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares after every rising edge.
// Honours JOHNSON_TDM_SCHEDULER_BORROW_EN for the borrow-dependent vectors.
module tb_johnson_tdm_scheduler;

`ifdef JOHNSON_TDM_SCHEDULER_BORROW_EN
  localparam bit BORROW = 1'b1;
`else
  localparam bit BORROW = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] slot;
    logic       pulse;
    logic [7:0] cnt;
    logic       busy;
    logic       err;
  } exp_t;

  logic       clk;
  logic       clear_n;
  logic       start;
  logic       stop;
  logic       flush;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] slot;
  logic       frame_pulse;
  logic [7:0] frame_cnt;
  logic       busy;
  logic       err;

  exp_t       sb[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         cur_slot     = 0;
  logic [7:0] exp_cnt      = 8'd0;
  logic       exp_err      = 1'b0;

  johnson_tdm_scheduler dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .start       (start),
    .stop        (stop),
    .flush       (flush),
    .req         (req),
    .gnt         (gnt),
    .slot        (slot),
    .frame_pulse (frame_pulse),
    .frame_cnt   (frame_cnt),
    .busy        (busy),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] want);
    tests_run++;
    if (act !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return one << (k % 4);
  endfunction

  function automatic exp_t mkExp(input logic [3:0] g, input int s, input logic p, input logic b);
    exp_t e;
    e.gnt   = g;
    e.slot  = 4'(s);
    e.pulse = p;
    e.cnt   = exp_cnt;
    e.busy  = b;
    e.err   = exp_err;
    return e;
  endfunction

  task automatic applyStimulus(input logic st, input logic sp, input logic fl,
                               input logic [3:0] r, input exp_t e);
    start = st;
    stop  = sp;
    flush = fl;
    req   = r;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic stepRun(input logic [3:0] r, input logic [3:0] g);
    logic p;
    p = (cur_slot == 15);
    if (p) exp_cnt = exp_cnt + 8'd1;
    cur_slot = (cur_slot + 1) % 16;
    applyStimulus(1'b0, 1'b0, 1'b0, r, mkExp(g, cur_slot, p, 1'b1));
  endtask

  task automatic stepHold(input logic st, input logic sp, input logic fl,
                          input logic [3:0] r, input logic b);
    applyStimulus(st, sp, fl, r, mkExp(4'b0000, cur_slot, 1'b0, b));
  endtask

  task automatic resetDut();
    clear_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    flush    = 1'b0;
    req      = 4'b0000;
    cur_slot = 0;
    exp_cnt  = 8'd0;
    exp_err  = 1'b0;
    sb.push_back(mkExp(4'b0000, 0, 1'b0, 1'b0));
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  // monitor: compare one scoreboard entry shortly after each rising edge
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("gnt",         8'(gnt),         8'(e.gnt));
        checkOutput("slot",        8'(slot),        8'(e.slot));
        checkOutput("frame_pulse", 8'(frame_pulse), 8'(e.pulse));
        checkOutput("frame_cnt",   frame_cnt,       e.cnt);
        checkOutput("busy",        8'(busy),        8'(e.busy));
        checkOutput("err",         8'(err),         8'(e.err));
      end
    end
  end

  // watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // directed stimulus sequence
  initial begin
    clear_n = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    flush   = 1'b0;
    req     = 4'b0000;
    @(negedge clk);
    resetDut();

    // all requesters: rotating one-hot grant, one frame
    stepHold(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
    for (int k = 0; k < 16; k++) stepRun(4'b1111, oh(k));
    // run to slot 15, then reset just before the frame would complete
    for (int k = 0; k < 15; k++) stepRun(4'b1111, oh(k));
    resetDut();

    // only requester 2 active
    stepHold(1'b1, 1'b0, 1'b0, 4'b0100, 1'b1);
    for (int k = 0; k < 16; k++)
      stepRun(4'b0100, (BORROW || (k % 4) == 2) ? 4'b0100 : 4'b0000);
    // requesters 0 and 1: idle slots 2,3 borrowed by 0 when enabled
    stepRun(4'b0011, 4'b0001);
    stepRun(4'b0011, 4'b0010);
    stepRun(4'b0011, BORROW ? 4'b0001 : 4'b0000);
    stepRun(4'b0011, BORROW ? 4'b0001 : 4'b0000);
    for (int k = 0; k < 4; k++) stepRun(4'b0000, 4'b0000);

    // pause at slot 5, resume, simultaneous start+stop, flush at slot 9
    resetDut();
    stepHold(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) stepRun(4'b1111, oh(k));
    stepHold(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1);
    repeat (3) stepHold(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    stepHold(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
    stepRun(4'b1111, oh(5));
    stepRun(4'b1111, oh(6));
    stepHold(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
    stepHold(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
    stepHold(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
    stepRun(4'b1111, oh(7));
    stepRun(4'b1111, oh(8));
    cur_slot = 0;
    stepHold(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    stepHold(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);

    // 256 frames: frame_cnt wraps to 0, then flush at slot 9
    resetDut();
    stepHold(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int k = 0; k < 4096; k++) stepRun(4'b0000, 4'b0000);
    for (int k = 0; k < 9; k++) stepRun(4'b1111, oh(k));
    cur_slot = 0;
    stepHold(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);

    // illegal Johnson pattern: reload to 0, sticky err, grant suppressed
    resetDut();
    stepHold(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
    for (int k = 0; k < 3; k++) stepRun(4'b1111, oh(k));
    force dut.jc = 8'b01010000;
    #1;
    release dut.jc;
    exp_err  = 1'b1;
    cur_slot = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, mkExp(4'b0000, 0, 1'b0, 1'b1));
    stepRun(4'b1111, oh(0));
    stepRun(4'b1111, oh(1));
    cur_slot = 0;
    stepHold(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    repeat (2) stepHold(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    resetDut();
    stepHold(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("sb_drain", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
